spi_master_pro: RTL and testbench

Parametrised, fully synchronous SPI master. It is the successor to the current fixed 32-bit SPI master and the team's new default master.
- Generalised: DATA_WIDTH, slave count, runtime bit length (1..DATA_WIDTH), wide programmable divider, MSB/LSB-first order, optional CS hold across transfers, done pulse.
- Single clock domain: SCLK is generated from a clock-enable tick, with no derived or gated clocks.
- Sits between a register/bus front-end and the external SPI pins.

---
 rtl/spi_master_pro.sv | 169 ++++++++++++++++
 tb/tb_spi_master_pro.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_pro.sv
// Parametrised single-clock SPI master: SCLK is a registered toggle driven by a
// divider tick, with runtime bit length, bit order, CPOL/CPHA and optional CS hold.
module spi_master_pro #(
    parameter int DATA_WIDTH      = 32,
    parameter int SLAVE_COUNT     = 8,
    parameter int SLAVE_ADDRS_LEN = 3,
    parameter int DIV_WIDTH       = 8,
    parameter int LEN_WIDTH       = $clog2(DATA_WIDTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_trans,
    output logic                       busy,
    output logic                       done,
    output logic                       MOSI,
    input  logic                       MISO,
    output logic                       SPI_SCLK,
    output logic [SLAVE_COUNT-1:0]     CS,
    input  logic [DATA_WIDTH-1:0]      tx_data,
    output logic [DATA_WIDTH-1:0]      rx_data,
    input  logic [SLAVE_ADDRS_LEN-1:0] chipADDRS,
    input  logic [LEN_WIDTH-1:0]       transaction_length,
    input  logic [DIV_WIDTH-1:0]       division_ratio,
    input  logic                       CPOL,
    input  logic                       CPHA,
    input  logic                       lsb_first,
    input  logic                       hold_cs,
    input  logic                       cs_release,
    input  logic                       default_val
);

    localparam int CNT_W = LEN_WIDTH + 2;
    localparam logic [SLAVE_COUNT-1:0] CS_OFF = {SLAVE_COUNT{1'b1}};

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [DATA_WIDTH-1:0]  tx_reg;
    logic [DATA_WIDTH-1:0]  rx_acc_reg;
    logic [DATA_WIDTH-1:0]  rx_data_reg;
    logic [LEN_WIDTH-1:0]   len_reg;
    logic [DIV_WIDTH-1:0]   div_reg;
    logic [DIV_WIDTH-1:0]   div_cnt_reg;
    logic [CNT_W-1:0]       edge_cnt_reg;
    logic [LEN_WIDTH-1:0]   tx_ptr_reg;
    logic [LEN_WIDTH-1:0]   rx_ptr_reg;
    logic [SLAVE_COUNT-1:0] cs_reg;
    logic                   cpol_reg, cpha_reg, lsb_reg, hold_reg;
    logic                   mosi_reg, sclk_reg;

    logic [SLAVE_COUNT-1:0] cs_target;
    logic [LEN_WIDTH-1:0]   first_ptr;
    logic                   idle, start_accept, tick, edge_fire;
    logic                   odd_edge, last_edge, do_shift, do_sample;

    // Out-of-range addresses match no select, so the transfer runs with all CS high.
    for (genvar gi = 0; gi < SLAVE_COUNT; gi++) begin : g_cs_decode
        assign cs_target[gi] = (chipADDRS != SLAVE_ADDRS_LEN'(gi));
    end

    function automatic logic [LEN_WIDTH-1:0] step_ptr(input logic [LEN_WIDTH-1:0] p,
                                                      input logic lsb);
        return lsb ? p + 1'b1 : p - 1'b1;
    endfunction

    assign idle         = (state_reg == S_IDLE);
    assign start_accept = idle && start_trans;
    assign first_ptr    = lsb_first ? '0 : transaction_length;
    assign tick         = (div_cnt_reg == div_reg);
    assign edge_fire    = tick && ((state_reg == S_SETUP) || (state_reg == S_XFER));
    // edge_cnt_reg holds completed edges, so the pending edge index is edge_cnt_reg+1.
    assign odd_edge     = ~edge_cnt_reg[0];
    assign last_edge    = (edge_cnt_reg == {1'b0, len_reg, 1'b1});
    assign do_sample    = edge_fire && (cpha_reg ? !odd_edge : odd_edge);
    assign do_shift     = edge_fire && (cpha_reg ? odd_edge : (!odd_edge && !last_edge));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= S_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_IDLE:  if (start_trans)       state_next = S_SETUP;
            S_SETUP: if (tick)              state_next = S_XFER;
            S_XFER:  if (tick && last_edge) state_next = S_HOLD;
            S_HOLD:  if (tick)              state_next = S_DONE;
            S_DONE:                         state_next = S_IDLE;
            default:                        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_reg       <= '0;
            rx_acc_reg   <= '0;
            rx_data_reg  <= '0;
            len_reg      <= '0;
            div_reg      <= '0;
            div_cnt_reg  <= '0;
            edge_cnt_reg <= '0;
            tx_ptr_reg   <= '0;
            rx_ptr_reg   <= '0;
            cs_reg       <= CS_OFF;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            lsb_reg      <= 1'b0;
            hold_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
        end else begin
            if (start_accept) begin
                tx_reg       <= tx_data;
                len_reg      <= transaction_length;
                div_reg      <= division_ratio;
                cpol_reg     <= CPOL;
                cpha_reg     <= CPHA;
                lsb_reg      <= lsb_first;
                hold_reg     <= hold_cs;
                cs_reg       <= cs_target;
                div_cnt_reg  <= '0;
                edge_cnt_reg <= '0;
                sclk_reg     <= CPOL;
                rx_acc_reg   <= '0;
                rx_ptr_reg   <= first_ptr;
                // CPHA=0 presents bit 0 of the stream before the first edge.
                if (CPHA) begin
                    mosi_reg   <= default_val;
                    tx_ptr_reg <= first_ptr;
                end else begin
                    mosi_reg   <= tx_data[first_ptr];
                    tx_ptr_reg <= step_ptr(first_ptr, lsb_first);
                end
            end else begin
                if (idle && cs_release)
                    cs_reg <= CS_OFF;
                if (!idle)
                    div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
                if (edge_fire) begin
                    sclk_reg     <= ~sclk_reg;
                    edge_cnt_reg <= edge_cnt_reg + 1'b1;
                end
                if (do_shift) begin
                    mosi_reg   <= tx_reg[tx_ptr_reg];
                    tx_ptr_reg <= step_ptr(tx_ptr_reg, lsb_reg);
                end
                if (do_sample) begin
                    rx_acc_reg[rx_ptr_reg] <= MISO;
                    rx_ptr_reg             <= step_ptr(rx_ptr_reg, lsb_reg);
                end
                if (state_reg == S_HOLD && tick)
                    rx_data_reg <= rx_acc_reg;
                // CS stays asserted through the done cycle and releases on return to idle.
                if (state_reg == S_DONE && !hold_reg)
                    cs_reg <= CS_OFF;
            end
        end
    end

    assign busy     = !idle;
    assign done     = (state_reg == S_DONE);
    assign MOSI     = idle ? default_val : mosi_reg;
    assign SPI_SCLK = idle ? CPOL : sclk_reg;
    assign CS       = cs_reg;
    assign rx_data  = rx_data_reg;

endmodule

// File: tb/tb_spi_master_pro.sv
// Scoreboard bench for spi_master_pro: MOSI is looped (optionally inverted) to MISO,
// expectations are queued at start and checked when done pulses.
module tb_spi_master_pro;

    localparam int DW = 32;
    localparam int SC = 6;
    localparam int AL = 3;
    localparam int DIVW = 8;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_trans, busy, done, MOSI, MISO, SPI_SCLK;
    logic [SC-1:0] CS;
    logic [DW-1:0] tx_data, rx_data;
    logic [AL-1:0] chipADDRS;
    logic [LW-1:0] transaction_length;
    logic [DIVW-1:0] division_ratio;
    logic          CPOL, CPHA, lsb_first, hold_cs, cs_release, default_val;
    logic          miso_inv;

    localparam logic [SC-1:0] ALL_OFF = {SC{1'b1}};

    spi_master_pro #(
        .DATA_WIDTH(DW), .SLAVE_COUNT(SC), .SLAVE_ADDRS_LEN(AL),
        .DIV_WIDTH(DIVW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst), .start_trans(start_trans), .busy(busy), .done(done),
        .MOSI(MOSI), .MISO(MISO), .SPI_SCLK(SPI_SCLK), .CS(CS),
        .tx_data(tx_data), .rx_data(rx_data), .chipADDRS(chipADDRS),
        .transaction_length(transaction_length), .division_ratio(division_ratio),
        .CPOL(CPOL), .CPHA(CPHA), .lsb_first(lsb_first), .hold_cs(hold_cs),
        .cs_release(cs_release), .default_val(default_val)
    );

    assign MISO = MOSI ^ miso_inv;

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rx;
        int            done_cyc;
        int            n;
        int            h;
        logic [SC-1:0] cs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   xfer_id = 0;
    int   rises = 0;
    int   bad_gap = 0;
    int   last_t = 0;
    logic prev_sclk = 1'b0;
    logic prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [SC-1:0] cs_for(input int addr);
        logic [SC-1:0] v;
        v = ALL_OFF;
        if (addr < SC) v[addr] = 1'b0;
        return v;
    endfunction

    // Monitor: SCLK edge count and half-period spacing, then scoreboard pop on done.
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            rises   = 0;
            bad_gap = 0;
            last_t  = cyc;
        end else if (busy && prev_busy && SPI_SCLK !== prev_sclk && exp_q.size() > 0) begin
            if (SPI_SCLK) rises++;
            if (cyc - last_t != exp_q[0].h) bad_gap++;
            last_t = cyc;
        end
        if (done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                xfer_id++;
                $display("[TB] xfer %0d: n=%0d h=%0d rx=0x%08h exp=0x%08h done@%0d exp@%0d",
                         xfer_id, e.n, e.h, rx_data, e.rx, cyc, e.done_cyc);
                check("rx_data", 64'(rx_data), 64'(e.rx));
                check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                check("sclk_rises", 64'(rises), 64'(e.n));
                check("sclk_gaps", 64'(bad_gap), 64'd0);
                check("cs_at_done", 64'(CS), 64'(e.cs));
                check("busy_at_done", 64'(busy), 64'd1);
            end
        end
        prev_sclk = SPI_SCLK;
        prev_busy = busy;
    end

    // Called just after a negedge; the next posedge is the latch edge k.
    task automatic start_xfer(input logic [DW-1:0] tx, input int len, input int div,
                              input logic cpol, input logic cpha, input logic lsb,
                              input logic hold, input int addr, input logic keep,
                              output int done_cyc);
        exp_t          e;
        int            n;
        int            h;
        logic [63:0]   mask;
        logic [DW-1:0] txw;
        n = len + 1;
        h = div + 1;
        txw = tx;
        tx_data            = tx;
        transaction_length = len[LW-1:0];
        division_ratio     = div[DIVW-1:0];
        CPOL               = cpol;
        CPHA               = cpha;
        lsb_first          = lsb;
        hold_cs            = hold;
        chipADDRS          = addr[AL-1:0];
        start_trans        = 1'b1;
        mask       = (64'd1 << n) - 64'd1;
        e.rx       = DW'(64'(tx ^ {DW{miso_inv}}) & mask);
        e.done_cyc = cyc + 1 + (2 * n + 1) * h;
        e.n        = n;
        e.h        = h;
        e.cs       = cs_for(addr);
        exp_q.push_back(e);
        done_cyc = e.done_cyc;
        @(negedge clk);
        if (!keep) begin
            start_trans        = 1'b0;
            tx_data            = $urandom;
            transaction_length = LW'($urandom);
            division_ratio     = DIVW'($urandom);
            chipADDRS          = AL'($urandom);
            CPHA               = ~cpha;
            lsb_first          = ~lsb;
        end
        check("busy_k1", 64'(busy), 64'd1);
        check("cs_k1", 64'(CS), 64'(e.cs));
        if (cpha) repeat (h) @(negedge clk);
        check("mosi_first", 64'(MOSI), 64'(lsb ? txw[0] : txw[len]));
    endtask

    task automatic finish_xfer(input logic hold, input int addr, input int done_cyc);
        int i;
        i = 0;
        while (busy && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("busy_timeout", 64'(busy), 64'd0);
        check("busy_fall_cycle", 64'(cyc), 64'(done_cyc + 1));
        check("cs_after", 64'(CS), 64'(hold ? cs_for(addr) : ALL_OFF));
        check("sb_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_xfer(input logic [DW-1:0] tx, input int len, input int div,
                            input logic cpol, input logic cpha, input logic lsb,
                            input logic hold, input int addr);
        int dc;
        start_xfer(tx, len, div, cpol, cpha, lsb, hold, addr, 1'b0, dc);
        finish_xfer(hold, addr, dc);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dc;
        int saved;
        rst = 1'b0;
        start_trans = 1'b0; tx_data = '0; chipADDRS = '0; transaction_length = '0;
        division_ratio = '0; CPOL = 1'b1; CPHA = 1'b0; lsb_first = 1'b0;
        hold_cs = 1'b0; cs_release = 1'b0; default_val = 1'b0; miso_inv = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cs", 64'(CS), 64'(ALL_OFF));
        check("rst_rx", 64'(rx_data), 64'd0);
        check("rst_sclk_hi", 64'(SPI_SCLK), 64'd1);
        check("rst_mosi_lo", 64'(MOSI), 64'd0);
        CPOL = 1'b0; default_val = 1'b1;
        #1;
        check("rst_sclk_lo", 64'(SPI_SCLK), 64'd0);
        check("rst_mosi_hi", 64'(MOSI), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Mode 0, MSB first, 8 bits, fastest SCLK.
        run_xfer(32'h0000_00A5, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        // Mode 3, LSB first, 12 bits, div 1.
        run_xfer(32'h0000_05C3, 11, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        // Mode 1, full width, div 3.
        run_xfer(32'hDEAD_BEEF, 31, 3, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // CS hold across transfers, re-target, then release.
        run_xfer(32'h0000_003C, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        run_xfer(32'h0000_00C3, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        run_xfer(32'h0000_0096, 7, 1, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        cs_release = 1'b1;
        @(negedge clk);
        cs_release = 1'b0;
        check("cs_release", 64'(CS), 64'(ALL_OFF));

        // start_trans held high: no restart mid-transfer, back-to-back after busy falls.
        start_xfer(32'h0000_0071, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, dc);
        finish_xfer(1'b0, 0, dc);
        start_xfer(32'h0000_0071, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, dc);
        finish_xfer(1'b0, 0, dc);
        // Address beyond the select count: no CS asserted, done still pulses.
        run_xfer(32'h0000_005A, 7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 7);

        // Random modes, lengths, dividers and an inverted return path.
        for (int r = 0; r < 6; r++) begin
            miso_inv = 1'(r % 2);
            run_xfer($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'b0,
                     int'($urandom_range(0, 7)));
        end
        miso_inv = 1'b0;

        // Reset mid-transfer at SCLK edge 5 of 16.
        start_xfer(32'h0000_0000, 7, 1, 1'b1, 1'b0, 1'b0, 1'b0, 4, 1'b0, dc);
        CPOL = 1'b1; default_val = 1'b1;
        repeat (10) @(negedge clk);
        saved = done_seen;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("arst_cs", 64'(CS), 64'(ALL_OFF));
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_sclk", 64'(SPI_SCLK), 64'd1);
        check("arst_mosi", 64'(MOSI), 64'd1);
        check("arst_rx", 64'(rx_data), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("arst_no_done", 64'(done_seen), 64'(saved));
        check("arst_busy_after", 64'(busy), 64'd0);
        check("arst_rx_after", 64'(rx_data), 64'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
